// File: rtl/pc_unit_if.sv
// Bundles the PC unit's datapath inputs and status outputs.
// The master side drives control/datapath; the slave side is the PC unit.
interface pc_unit_if #(
  parameter int ADDR_W = 32,
  parameter int JTA_W  = 26
);
  logic [ADDR_W-1:0] alu_out;
  logic [ADDR_W-1:0] x_reg_out;
  logic [JTA_W-1:0]  jta;
  logic [ADDR_W-3:0] syscall;
  logic              jump_addr_sel;
  logic [1:0]        pc_src_sel;
  logic              pc_write;
  logic              pc_write_cond;
  logic              zero;
  logic              exc;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_src;
  logic [ADDR_W-1:0] z_reg_out;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;

  modport master (
    output alu_out, x_reg_out, jta, syscall, jump_addr_sel, pc_src_sel,
           pc_write, pc_write_cond, zero, exc, ras_push, ras_pop,
    input  pc, pc_src, z_reg_out, epc, ras_top, ras_empty, ras_full
  );

  modport slave (
    input  alu_out, x_reg_out, jta, syscall, jump_addr_sel, pc_src_sel,
           pc_write, pc_write_cond, zero, exc, ras_push, ras_pop,
    output pc, pc_src, z_reg_out, epc, ras_top, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter unit: next-PC selection, exception entry with EPC capture,
// ALU result register and a circular return-address stack.
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                JTA_W     = 26,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h8000_0180
) (
  input logic   clk,
  input logic   reset,
  pc_unit_if.slave bus
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] z_q;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] pc_src;
  logic [ADDR_W-3:0] jump_word;
  logic [ADDR_W-1:0] jump_target;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_m1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic              ras_empty, ras_full;

  // The jump target keeps the PC's upper region bits above the jta field.
  always_comb begin
    jump_word   = bus.jump_addr_sel ? bus.syscall
                                    : {pc_q[ADDR_W-1:JTA_W+2], bus.jta};
    jump_target = {jump_word, 2'b00};
    case (bus.pc_src_sel)
      2'b00:   pc_src = jump_target;
      2'b01:   pc_src = bus.x_reg_out;
      2'b10:   pc_src = z_q;
      default: pc_src = bus.alu_out;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (bus.exc) begin
      pc_d  = EXC_VEC;
      epc_d = pc_q;
    end else if (bus.pc_write || (bus.pc_write_cond && bus.zero)) begin
      pc_d = pc_src;
    end
  end

  assign ptr_m1    = ptr_q - PTR_ONE;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);

  // Push+pop on a non-empty stack rewrites the top in place.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (bus.ras_push && bus.ras_pop && !ras_empty) begin
      wr_en  = 1'b1;
      wr_idx = ptr_m1;
    end else if (bus.ras_push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = ptr_q + PTR_ONE;
      if (!ras_full) cnt_d = cnt_q + CNT_ONE;
    end else if (bus.ras_pop && !ras_empty) begin
      ptr_d = ptr_m1;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      z_q   <= '0;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      z_q   <= bus.alu_out;
      epc_q <= epc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) ras_mem[wr_idx] <= pc_q;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_src    = pc_src;
  assign bus.z_reg_out = z_q;
  assign bus.epc       = epc_q;
  assign bus.ras_top   = ras_empty ? '0 : ras_mem[ptr_m1];
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: reset, PC sources, conditional load,
// exceptions, return-address stack and reset override.
module tb_pc_unit;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  pc_unit_if #(.ADDR_W(32), .JTA_W(26)) bus ();
  pc_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_out = '0; bus.x_reg_out = '0; bus.jta = '0; bus.syscall = '0;
    bus.jump_addr_sel = 1'b0; bus.pc_src_sel = 2'b00; bus.pc_write = 1'b0;
    bus.pc_write_cond = 1'b0; bus.zero = 1'b0; bus.exc = 1'b0;
    bus.ras_push = 1'b0; bus.ras_pop = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    idle();
    bus.alu_out = v; bus.pc_src_sel = 2'b11; bus.pc_write = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", bus.pc); end
    tests++; if (bus.z_reg_out !== 32'h0) begin fails++; $display("FAIL reset_z got %h exp 0", bus.z_reg_out); end
    tests++; if (bus.epc !== 32'h0) begin fails++; $display("FAIL reset_epc got %h exp 0", bus.epc); end
    tests++; if (bus.ras_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", bus.ras_empty); end
    tests++; if (bus.ras_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", bus.ras_full); end
    tests++; if (bus.ras_top !== 32'h0) begin fails++; $display("FAIL reset_top got %h exp 0", bus.ras_top); end
  endtask

  task automatic test_sources();
    set_pc(32'h1000_0040);
    bus.jta = 26'h0000_100; bus.pc_src_sel = 2'b00;
    #1;
    tests++; if (bus.pc_src !== 32'h1000_0400) begin fails++; $display("FAIL jump_src got %h exp 10000400", bus.pc_src); end
    bus.jump_addr_sel = 1'b1; bus.syscall = 30'h0000_0123;
    #1;
    tests++; if (bus.pc_src !== 32'h0000_048C) begin fails++; $display("FAIL syscall_src got %h exp 0000048c", bus.pc_src); end
    bus.jump_addr_sel = 1'b0; bus.pc_write = 1'b1; bus.alu_out = 32'h0000_ABC0;
    step();
    tests++; if (bus.pc !== 32'h1000_0400) begin fails++; $display("FAIL jump_pc got %h exp 10000400", bus.pc); end
    tests++; if (bus.z_reg_out !== 32'h0000_ABC0) begin fails++; $display("FAIL z_capture got %h exp 0000abc0", bus.z_reg_out); end
    idle();
    bus.pc_src_sel = 2'b10;
    #1;
    tests++; if (bus.pc_src !== 32'h0000_ABC0) begin fails++; $display("FAIL zreg_src got %h exp 0000abc0", bus.pc_src); end
    bus.pc_src_sel = 2'b01; bus.x_reg_out = 32'hDEAD_BEE0;
    #1;
    tests++; if (bus.pc_src !== 32'hDEAD_BEE0) begin fails++; $display("FAIL xreg_src got %h exp deadbee0", bus.pc_src); end
    step();
    tests++; if (bus.pc !== 32'h1000_0400) begin fails++; $display("FAIL hold_pc got %h exp 10000400", bus.pc); end
    idle();
  endtask

  task automatic test_cond();
    set_pc(32'h0000_0100);
    bus.pc_write_cond = 1'b1; bus.alu_out = 32'h0000_0088; bus.pc_src_sel = 2'b11; bus.zero = 1'b0;
    step();
    tests++; if (bus.pc !== 32'h0000_0100) begin fails++; $display("FAIL cond_nz got %h exp 00000100", bus.pc); end
    bus.zero = 1'b1;
    step();
    tests++; if (bus.pc !== 32'h0000_0088) begin fails++; $display("FAIL cond_z got %h exp 00000088", bus.pc); end
    idle();
  endtask

  task automatic test_exc();
    set_pc(32'h0000_0200);
    bus.exc = 1'b1; bus.pc_write = 1'b1; bus.pc_src_sel = 2'b11; bus.alu_out = 32'h0000_0444;
    step();
    tests++; if (bus.pc !== 32'h8000_0180) begin fails++; $display("FAIL exc_pc got %h exp 80000180", bus.pc); end
    tests++; if (bus.epc !== 32'h0000_0200) begin fails++; $display("FAIL exc_epc got %h exp 00000200", bus.epc); end
    tests++; if (bus.z_reg_out !== 32'h0000_0444) begin fails++; $display("FAIL exc_z got %h exp 00000444", bus.z_reg_out); end
    idle();
    bus.pc_write = 1'b1; bus.pc_src_sel = 2'b11; bus.alu_out = 32'h0000_0300;
    step();
    tests++; if (bus.epc !== 32'h0000_0200) begin fails++; $display("FAIL epc_hold got %h exp 00000200", bus.epc); end
    tests++; if (bus.pc !== 32'h0000_0300) begin fails++; $display("FAIL post_exc_pc got %h exp 00000300", bus.pc); end
    idle();
  endtask

  task automatic test_ras();
    logic [31:0] pops [3];
    pops[0] = 32'h40; pops[1] = 32'h30; pops[2] = 32'h20;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      set_pc(32'(i * 16));
      bus.ras_push = 1'b1;
      step();
      idle();
      tests++; if (bus.ras_top !== 32'(i * 16)) begin fails++; $display("FAIL push_top[%0d] got %h exp %h", i, bus.ras_top, 32'(i * 16)); end
      tests++; if (bus.ras_full !== (i >= 4)) begin fails++; $display("FAIL push_full[%0d] got %b exp %b", i, bus.ras_full, (i >= 4)); end
    end
    for (int i = 0; i < 3; i++) begin
      bus.ras_pop = 1'b1;
      step();
      idle();
      tests++; if (bus.ras_top !== pops[i]) begin fails++; $display("FAIL pop_top[%0d] got %h exp %h", i, bus.ras_top, pops[i]); end
      tests++; if (bus.ras_full !== 1'b0 || bus.ras_empty !== 1'b0) begin fails++; $display("FAIL pop_flags[%0d] got full=%b empty=%b exp 0 0", i, bus.ras_full, bus.ras_empty); end
    end
    for (int i = 0; i < 2; i++) begin
      bus.ras_pop = 1'b1;
      step();
      idle();
      tests++; if (bus.ras_empty !== 1'b1 || bus.ras_top !== 32'h0) begin fails++; $display("FAIL pop_empty[%0d] got empty=%b top=%h exp 1 0", i, bus.ras_empty, bus.ras_top); end
    end
    set_pc(32'h77);
    bus.ras_push = 1'b1;
    step();
    idle();
    tests++; if (bus.ras_top !== 32'h77) begin fails++; $display("FAIL push_after_empty got %h exp 00000077", bus.ras_top); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_pc(32'h10);
    bus.ras_push = 1'b1;
    step();
    set_pc(32'h99);
    bus.ras_push = 1'b1; bus.ras_pop = 1'b1;
    step();
    idle();
    tests++; if (bus.ras_top !== 32'h99) begin fails++; $display("FAIL pushpop_top got %h exp 00000099", bus.ras_top); end
    bus.ras_pop = 1'b1;
    step();
    idle();
    tests++; if (bus.ras_empty !== 1'b1) begin fails++; $display("FAIL pushpop_count got empty=%b exp 1", bus.ras_empty); end
    bus.ras_push = 1'b1; bus.ras_pop = 1'b1;
    step();
    idle();
    tests++; if (bus.ras_top !== 32'h99 || bus.ras_empty !== 1'b0) begin fails++; $display("FAIL pushpop_empty got top=%h empty=%b exp 99 0", bus.ras_top, bus.ras_empty); end
    bus.exc = 1'b1; bus.alu_out = 32'h55;
    step();
    idle();
    reset = 1'b1;
    bus.exc = 1'b1; bus.pc_write = 1'b1; bus.pc_src_sel = 2'b11; bus.alu_out = 32'h1234;
    bus.ras_push = 1'b1;
    step();
    reset = 1'b0;
    idle();
    tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL mid_reset_pc got %h exp 0", bus.pc); end
    tests++; if (bus.epc !== 32'h0) begin fails++; $display("FAIL mid_reset_epc got %h exp 0", bus.epc); end
    tests++; if (bus.z_reg_out !== 32'h0) begin fails++; $display("FAIL mid_reset_z got %h exp 0", bus.z_reg_out); end
    tests++; if (bus.ras_empty !== 1'b1 || bus.ras_top !== 32'h0) begin fails++; $display("FAIL mid_reset_ras got empty=%b top=%h exp 1 0", bus.ras_empty, bus.ras_top); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    test_reset();
    test_sources();
    test_cond();
    test_exc();
    test_ras();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, 32, PC and datapath address width.
REQ-002 Parameter JTA_W, 26, jump-target field width; ADDR_W-JTA_W-2 SHALL be >= 1.
REQ-003 Parameter RAS_DEPTH, 4, return-address-stack entries, power of two, >= 2.
REQ-004 Parameter RESET_PC, 32'h0000_0000, PC value after reset.
REQ-005 Parameter EXC_VEC, 32'h8000_0180, exception entry address.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 alu_out  input  ADDR_W  ALU result (PC+4 or branch target).
REQ-009 x_reg_out  input  ADDR_W  register-indirect target.
REQ-010 jta  input  JTA_W  instruction jump-target field.
REQ-011 syscall  input  ADDR_W-2  syscall word address.
REQ-012 jump_addr_sel  input  1  0 = {pc upper bits, jta}, 1 = syscall.
REQ-013 pc_src_sel  input  2  next-PC source select.
REQ-014 pc_write  input  1  unconditional PC load.
REQ-015 pc_write_cond  input  1  PC load qualified by zero.
REQ-016 zero  input  1  ALU zero flag.
REQ-017 exc  input  1  exception request.
REQ-018 ras_push  input  1  push pc onto RAS.
REQ-019 ras_pop  input  1  pop RAS.
REQ-020 pc  output  ADDR_W  current PC register.
REQ-021 pc_src  output  ADDR_W  combinational next-PC candidate.
REQ-022 z_reg_out  output  ADDR_W  registered alu_out.
REQ-023 epc  output  ADDR_W  exception PC register.
REQ-024 ras_top  output  ADDR_W  top RAS entry; 0 when empty.
REQ-025 ras_empty / ras_full  output  1 each  RAS occupancy flags.

Function
REQ-026 z_reg_out SHALL capture alu_out every non-reset cycle, one-cycle latency.
REQ-027 Jump word address SHALL be {pc[ADDR_W-1:JTA_W+2], jta} when jump_addr_sel=0, else syscall; jump target SHALL be that word address with 2'b00 appended.
REQ-028 pc_src SHALL be: 00 jump target, 01 x_reg_out, 10 z_reg_out, 11 alu_out.
REQ-029 Next-cycle pc priority: exc -> EXC_VEC; else pc_write or (pc_write_cond and zero) -> pc_src; else hold.
REQ-030 On exc, epc SHALL load current pc in the same edge; epc SHALL otherwise hold.
REQ-031 exc SHALL NOT alter RAS or z_reg_out behaviour.
REQ-032 RAS SHALL be circular with write pointer and saturating count 0..RAS_DEPTH.
REQ-033 Push, not full: write pc at pointer, pointer+1, count+1.
REQ-034 Push, full: overwrite oldest entry, pointer+1 (mod RAS_DEPTH), count stays RAS_DEPTH.
REQ-035 Pop, non-empty: pointer-1, count-1; pop when empty SHALL be ignored.
REQ-036 Push and pop in the same cycle: non-empty -> replace top with pc, count unchanged; empty -> plain push.
REQ-037 ras_top SHALL be the entry at pointer-1 (mod RAS_DEPTH) when count>0, else 0; flags SHALL be combinational from count.

Reset
REQ-038 On reset: pc=RESET_PC, z_reg_out=0, epc=0, RAS count=0, pointer=0, entries=0.
REQ-039 Reset SHALL override every other input in the same cycle, including exc and RAS push/pop.

Verification
REQ-040 Reset then idle -> pc=0, z_reg_out=0, epc=0, ras_empty=1, ras_top=0.
REQ-041 pc=32'h1000_0040, jta=26'h0000_100, sel=00, pc_write=1 -> pc_src=32'h1000_0400, pc=32'h1000_0400 next cycle.
REQ-042 pc_write_cond=1, alu_out=32'h0000_0088, sel=11: zero=0 -> pc holds; zero=1 -> pc=32'h0000_0088.
REQ-043 pc=32'h0000_0200, exc=1 and pc_write=1 together -> pc=32'h8000_0180, epc=32'h0000_0200.
REQ-044 Five pushes of pc = 0x10,0x20,0x30,0x40,0x50 -> ras_full=1, ras_top=0x50; four pops -> ras_top 0x40,0x30,0x20, then empty; fifth pop ignored.
REQ-045 Push+pop with one entry 0x10 and pc=0x99 -> ras_top=0x99, count stays 1; reset asserted mid-sequence -> all state at reset values next cycle.
